// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared definitions for the full-search motion estimator:
//   - me_state_e : engine FSM states
//   - width helpers derived from the block/range geometry
//   - abs_diff   : absolute pixel difference
// ---------------------------------------------------------------------------
package me_pkg;

    typedef enum logic [2:0] {IDLE, RUN, LAST, CMP, DONE} me_state_e;

    // Widest pixel abs_diff handles; callers zero-extend narrower pixels.
    localparam int PIX_MAX_W = 16;

    // Search-window edge in pixels.
    function automatic int sw_size(input int blk, input int rng);
        return blk + 2 * rng - 1;
    endfunction

    function automatic int ar_width(input int blk);
        return $clog2(blk * blk);
    endfunction

    function automatic int as_width(input int blk, input int rng);
        return $clog2(sw_size(blk, rng) * sw_size(blk, rng));
    endfunction

    // SAD width: one pixel's worth of bits plus one bit per doubling of pixel count.
    function automatic int d_width(input int blk, input int pix_w);
        return ar_width(blk) + pix_w;
    endfunction

    function automatic int m_width(input int rng);
        return $clog2(rng) + 1;
    endfunction

    // |a-b| computed one bit wider so the sign of the difference is visible.
    function automatic logic [PIX_MAX_W-1:0] abs_diff(input logic [PIX_MAX_W-1:0] a,
                                                      input logic [PIX_MAX_W-1:0] b);
        logic [PIX_MAX_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[PIX_MAX_W]) d = -d;
        return d[PIX_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/me_addr_gen.sv
// ---------------------------------------------------------------------------
// me_addr_gen
// Pixel and candidate counters for the full-search engine.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_init         : restart at pixel 0 of candidate (-RANGE,-RANGE)
//   i_step         : advance to the next pixel of the current candidate
//   i_next         : advance to the next candidate (raster, dx inner)
//   o_addr_r       : reference-block address  row*BLK + col
//   o_addr_s       : search-window address    (row+dy+RANGE)*SW + (col+dx+RANGE)
//   o_last_pixel   : current address is the final pixel of the block
//   o_last_cand    : current candidate is the final one of the scan
//   o_dx, o_dy     : signed displacement of the current candidate
// ---------------------------------------------------------------------------
module me_addr_gen
    import me_pkg::*;
#(
    parameter  int BLK   = 16,
    parameter  int RANGE = 8,
    localparam int SW    = sw_size(BLK, RANGE),
    localparam int AR_W  = ar_width(BLK),
    localparam int AS_W  = as_width(BLK, RANGE),
    localparam int M_W   = m_width(RANGE),
    localparam int CW    = $clog2(BLK)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_init,
    input  logic                  i_step,
    input  logic                  i_next,
    output logic [AR_W-1:0]       o_addr_r,
    output logic [AS_W-1:0]       o_addr_s,
    output logic                  o_last_pixel,
    output logic                  o_last_cand,
    output logic signed [M_W-1:0] o_dx,
    output logic signed [M_W-1:0] o_dy
);

    localparam logic [M_W-1:0] OFS_MAX = M_W'(2 * RANGE - 1);

    // Displacements are kept as offsets 0..2*RANGE-1 so the window address
    // needs no signed arithmetic.
    logic [AR_W-1:0] r_pix;
    logic [M_W-1:0]  r_ox;
    logic [M_W-1:0]  r_oy;
    logic [CW-1:0]   w_row;
    logic [CW-1:0]   w_col;
    logic [AS_W-1:0] w_srow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix <= '0;
            r_ox  <= '0;
            r_oy  <= '0;
        end else if (i_init) begin
            r_pix <= '0;
            r_ox  <= '0;
            r_oy  <= '0;
        end else if (i_next) begin
            // Also reached after an early abort, so the pixel count restarts here.
            // dy wraps after the final candidate to keep the idle address in range.
            r_pix <= '0;
            if (r_ox == OFS_MAX) begin
                r_ox <= '0;
                r_oy <= (r_oy == OFS_MAX) ? '0 : r_oy + M_W'(1);
            end else begin
                r_ox <= r_ox + M_W'(1);
            end
        end else if (i_step) begin
            // BLK is a power of two, so {row,col} is a single wrapping counter.
            r_pix <= r_pix + AR_W'(1);
        end
    end

    assign w_row        = r_pix[AR_W-1:CW];
    assign w_col        = r_pix[CW-1:0];
    assign w_srow       = AS_W'(w_row) + AS_W'(r_oy);
    assign o_addr_r     = r_pix;
    assign o_addr_s     = w_srow * AS_W'(SW) + AS_W'(w_col) + AS_W'(r_ox);
    assign o_last_pixel = (r_pix == '1);
    assign o_last_cand  = (r_ox == OFS_MAX) && (r_oy == OFS_MAX);
    assign o_dx         = $signed(r_ox - M_W'(RANGE));
    assign o_dy         = $signed(r_oy - M_W'(RANGE));

endmodule

// File: rtl/me_fullsearch_engine.sv
// ---------------------------------------------------------------------------
// me_fullsearch_engine
// Full-search SAD block matcher: BLK x BLK reference block against every
// displacement (-RANGE..RANGE-1)^2 inside an SW x SW search window.
//   clock, rst_n        : clock, asynchronous active-low reset
//   start               : request, accepted only in IDLE
//   busy                : search in progress
//   completed           : one-cycle pulse, results valid
//   BestDist            : minimum SAD, held until the next search ends
//   motionX, motionY    : signed displacement of the first minimum (raster)
//   AddressR, AddressS  : ROM addresses (data returns one cycle later)
//   R, S                : ROM data
// EARLY_TERM=1 abandons a candidate once its partial SAD reaches the best
// so far; results are unchanged, only the cycle count drops.
// ---------------------------------------------------------------------------
module me_fullsearch_engine
    import me_pkg::*;
#(
    parameter  int BLK        = 16,
    parameter  int RANGE      = 8,
    parameter  int PIX_W      = 8,
    parameter  int EARLY_TERM = 1,
    localparam int AR_W       = ar_width(BLK),
    localparam int AS_W       = as_width(BLK, RANGE),
    localparam int D_W        = d_width(BLK, PIX_W),
    localparam int M_W        = m_width(RANGE)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  completed,
    output logic [D_W-1:0]        BestDist,
    output logic signed [M_W-1:0] motionX,
    output logic signed [M_W-1:0] motionY,
    output logic [AR_W-1:0]       AddressR,
    output logic [AS_W-1:0]       AddressS,
    input  logic [PIX_W-1:0]      R,
    input  logic [PIX_W-1:0]      S
);

    me_state_e             r_state;
    logic [D_W-1:0]        r_acc;
    logic [D_W-1:0]        r_best;
    logic signed [M_W-1:0] r_bx;
    logic signed [M_W-1:0] r_by;
    logic                  r_vld;   // R/S currently carry data for an issued address

    logic                  w_init;
    logic                  w_step;
    logic                  w_next;
    logic                  w_last_pixel;
    logic                  w_last_cand;
    logic                  w_abort;
    logic signed [M_W-1:0] w_dx;
    logic signed [M_W-1:0] w_dy;
    logic [PIX_W-1:0]      w_ad;
    logic [D_W-1:0]        w_sum;

    assign w_init = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN);
    assign w_next = (r_state == CMP);

    me_addr_gen #(
        .BLK   (BLK),
        .RANGE (RANGE)
    ) u_addr_gen (
        .i_clk        (clock),
        .i_rst_n      (rst_n),
        .i_init       (w_init),
        .i_step       (w_step),
        .i_next       (w_next),
        .o_addr_r     (AddressR),
        .o_addr_s     (AddressS),
        .o_last_pixel (w_last_pixel),
        .o_last_cand  (w_last_cand),
        .o_dx         (w_dx),
        .o_dy         (w_dy)
    );

    assign w_ad  = PIX_W'(abs_diff(PIX_MAX_W'(R), PIX_MAX_W'(S)));
    assign w_sum = r_acc + {{AR_W{1'b0}}, w_ad};

    // The first candidate can never abort: best starts at all-ones, above any SAD.
    assign w_abort = (EARLY_TERM != 0) && r_vld && (w_sum >= r_best);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            completed <= 1'b0;
            BestDist  <= '0;
            motionX   <= '0;
            motionY   <= '0;
            r_acc     <= '0;
            r_best    <= '0;
            r_bx      <= '0;
            r_by      <= '0;
            r_vld     <= 1'b0;
        end else begin
            completed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        busy    <= 1'b1;
                        r_acc   <= '0;
                        r_best  <= '1;
                        r_vld   <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_vld) r_acc <= w_sum;
                    if (w_abort) begin
                        // acc is left >= best, so CMP will not take this candidate.
                        r_vld   <= 1'b0;
                        r_state <= CMP;
                    end else begin
                        r_vld <= 1'b1;
                        if (w_last_pixel) r_state <= LAST;
                    end
                end
                LAST: begin
                    r_acc   <= w_sum;
                    r_vld   <= 1'b0;
                    r_state <= CMP;
                end
                CMP: begin
                    // Strict compare: ties keep the earlier candidate.
                    if (r_acc < r_best) begin
                        r_best <= r_acc;
                        r_bx   <= w_dx;
                        r_by   <= w_dy;
                    end
                    r_acc   <= '0;
                    r_state <= w_last_cand ? DONE : RUN;
                end
                DONE: begin
                    BestDist  <= r_best;
                    motionX   <= r_bx;
                    motionY   <= r_by;
                    completed <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_fullsearch_engine.sv
`timescale 1ns/1ps
module tb_me_fullsearch_engine;

    typedef logic [7:0] pix_t;
    typedef pix_t mem_t [0:1023];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: evaluate every candidate in raster order, keep the first minimum.
    task automatic ref_search(input int blk, input int rng, input mem_t rr, input mem_t ss,
                              output int best, output int bx, output int by);
        int sw, sad, a, b;
        sw = blk + 2 * rng - 1;
        best = -1; bx = 0; by = 0;
        for (int dy = -rng; dy < rng; dy++) begin
            for (int dx = -rng; dx < rng; dx++) begin
                sad = 0;
                for (int row = 0; row < blk; row++) begin
                    for (int col = 0; col < blk; col++) begin
                        a = int'(rr[row * blk + col]);
                        b = int'(ss[(row + dy + rng) * sw + col + dx + rng]);
                        sad += (a > b) ? a - b : b - a;
                    end
                end
                if (best < 0 || sad < best) begin
                    best = sad; bx = dx; by = dy;
                end
            end
        end
    endtask

    logic rst_glb_n = 1'b1;
    logic rst_b_n   = 1'b1;
    logic rst_nB;
    assign rst_nB = rst_glb_n & rst_b_n;

    bit rel = 1'b0;
    bit doneA = 1'b0, doneB = 1'b0, doneC = 1'b0, doneD = 1'b0;
    int nComplA = 0, nComplB = 0, nComplD = 0;

    mem_t memRA, memSA, memRB, memSB, memRD, memSD, memRC, memSC;

    // 16x16 / +-8 instances: A (full SAD), B (early term), D (full SAD)
    logic startA = 1'b0, startB = 1'b0, startD = 1'b0, startC = 1'b0;
    logic busyA, complA, busyB, complB, busyD, complD;
    logic [15:0] bestA, bestB, bestD;
    logic signed [3:0] mxA, myA, mxB, myB, mxD, myD;
    logic [7:0] arA, arB, arD;
    logic [9:0] asA, asB, asD;
    logic [7:0] rA_q, sA_q, rB_q, sB_q, rD_q, sD_q;

    // 4x4 / +-2 instances sharing one data set: C0 (full SAD), C1 (early term)
    logic busyC0, complC0, busyC1, complC1;
    logic [11:0] bestC0, bestC1;
    logic signed [1:0] mxC0, myC0, mxC1, myC1;
    logic [3:0] arC0, arC1;
    logic [5:0] asC0, asC1;
    logic [7:0] rC0_q, sC0_q, rC1_q, sC1_q;

    me_fullsearch_engine #(.BLK(16), .RANGE(8), .PIX_W(8), .EARLY_TERM(0)) u_dut_a (
        .clock(clk), .rst_n(rst_glb_n), .start(startA), .busy(busyA), .completed(complA),
        .BestDist(bestA), .motionX(mxA), .motionY(myA), .AddressR(arA), .AddressS(asA),
        .R(rA_q), .S(sA_q));

    me_fullsearch_engine #(.BLK(16), .RANGE(8), .PIX_W(8), .EARLY_TERM(1)) u_dut_b (
        .clock(clk), .rst_n(rst_nB), .start(startB), .busy(busyB), .completed(complB),
        .BestDist(bestB), .motionX(mxB), .motionY(myB), .AddressR(arB), .AddressS(asB),
        .R(rB_q), .S(sB_q));

    me_fullsearch_engine #(.BLK(16), .RANGE(8), .PIX_W(8), .EARLY_TERM(0)) u_dut_d (
        .clock(clk), .rst_n(rst_glb_n), .start(startD), .busy(busyD), .completed(complD),
        .BestDist(bestD), .motionX(mxD), .motionY(myD), .AddressR(arD), .AddressS(asD),
        .R(rD_q), .S(sD_q));

    me_fullsearch_engine #(.BLK(4), .RANGE(2), .PIX_W(8), .EARLY_TERM(0)) u_dut_c0 (
        .clock(clk), .rst_n(rst_glb_n), .start(startC), .busy(busyC0), .completed(complC0),
        .BestDist(bestC0), .motionX(mxC0), .motionY(myC0), .AddressR(arC0), .AddressS(asC0),
        .R(rC0_q), .S(sC0_q));

    me_fullsearch_engine #(.BLK(4), .RANGE(2), .PIX_W(8), .EARLY_TERM(1)) u_dut_c1 (
        .clock(clk), .rst_n(rst_glb_n), .start(startC), .busy(busyC1), .completed(complC1),
        .BestDist(bestC1), .motionX(mxC1), .motionY(myC1), .AddressR(arC1), .AddressS(asC1),
        .R(rC1_q), .S(sC1_q));

    // Synchronous ROMs: data one cycle after the address.
    always @(posedge clk) begin
        rA_q  <= memRA[arA];  sA_q  <= memSA[asA];
        rB_q  <= memRB[arB];  sB_q  <= memSB[asB];
        rD_q  <= memRD[arD];  sD_q  <= memSD[asD];
        rC0_q <= memRC[arC0]; sC0_q <= memSC[asC0];
        rC1_q <= memRC[arC1]; sC1_q <= memSC[asC1];
    end

    // Window addresses must stay inside the window at all times.
    always @(negedge clk) begin
        if (rel) begin
            chk("A_addrS_in_range",  int'(asA  < 10'd961), 1);
            chk("B_addrS_in_range",  int'(asB  < 10'd961), 1);
            chk("D_addrS_in_range",  int'(asD  < 10'd961), 1);
            chk("C0_addrS_in_range", int'(asC0 < 6'd49), 1);
            chk("C1_addrS_in_range", int'(asC1 < 6'd49), 1);
        end
        if (complA) nComplA++;
        if (complB) nComplB++;
        if (complD) nComplD++;
    end

    initial begin : thr_a
        int eb, ex, ey, t0, n;
        for (int i = 0; i < 1024; i++) memSA[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) memRA[i] = 8'd0;
        // Reference block cut from the window at displacement (+3,-2).
        for (int row = 0; row < 16; row++)
            for (int col = 0; col < 16; col++)
                memRA[row * 16 + col] = memSA[(row - 2 + 8) * 31 + col + 3 + 8];
        ref_search(16, 8, memRA, memSA, eb, ex, ey);
        chk("model_offset_best", eb, 0);
        chk("model_offset_mx", ex, 3);
        chk("model_offset_my", ey, -2);
        wait (rel);
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0; t0 = cyc;
        chk("A_busy_after_start", int'(busyA), 1);
        repeat (100) @(negedge clk);
        chk("A_best_held_during_search", int'(bestA), 0);
        startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        chk("A_busy_after_restart", int'(busyA), 1);
        n = 0;
        while (!complA && n < 70000) begin @(negedge clk); n++; end
        chk("A_completed_seen", int'(complA), 1);
        chk("A_latency", cyc - t0, 66049);
        chk("A_best_model", int'(bestA), eb);
        chk("A_mx_model", int'(mxA), ex);
        chk("A_my_model", int'(myA), ey);
        chk("A_best_literal", int'(bestA), 0);
        chk("A_mx_literal", int'(mxA), 3);
        chk("A_my_literal", int'(myA), -2);
        chk("A_busy_at_done", int'(busyA), 0);
        @(negedge clk);
        chk("A_completed_single_pulse", int'(complA), 0);
        chk("A_mx_held", int'(mxA), 3);
        doneA = 1'b1;
    end

    initial begin : thr_b
        int eb, ex, ey, t0, n;
        for (int i = 0; i < 1024; i++) begin memRB[i] = 8'hFF; memSB[i] = 8'h00; end
        wait (rel);
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        repeat (4999) @(negedge clk);
        rst_b_n = 1'b0;
        #1;
        chk("B_rst_busy", int'(busyB), 0);
        chk("B_rst_completed", int'(complB), 0);
        chk("B_rst_best", int'(bestB), 0);
        chk("B_rst_mx", int'(mxB), 0);
        chk("B_rst_my", int'(myB), 0);
        chk("B_rst_addrR", int'(arB), 0);
        chk("B_rst_addrS", int'(asB), 0);
        @(negedge clk); @(negedge clk);
        rst_b_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("B_no_pulse_after_abort", nComplB, 0);
        chk("B_idle_after_reset", int'(busyB), 0);
        for (int i = 0; i < 1024; i++) begin memRB[i] = 8'h55; memSB[i] = 8'h55; end
        ref_search(16, 8, memRB, memSB, eb, ex, ey);
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0; t0 = cyc;
        n = 0;
        while (!complB && n < 70000) begin @(negedge clk); n++; end
        chk("B_completed_seen", int'(complB), 1);
        chk("B_best_model", int'(bestB), eb);
        chk("B_mx_model", int'(mxB), ex);
        chk("B_my_model", int'(myB), ey);
        chk("B_best_literal", int'(bestB), 0);
        chk("B_mx_literal", int'(mxB), -8);
        chk("B_my_literal", int'(myB), -8);
        chk("B_early_term_faster", int'((cyc - t0) < 66049), 1);
        doneB = 1'b1;
    end

    initial begin : thr_d
        int eb, ex, ey, t0, n;
        for (int i = 0; i < 1024; i++) begin memRD[i] = 8'hFF; memSD[i] = 8'h00; end
        ref_search(16, 8, memRD, memSD, eb, ex, ey);
        wait (rel);
        @(negedge clk); startD = 1'b1;
        @(negedge clk); startD = 1'b0; t0 = cyc;
        n = 0;
        while (!complD && n < 70000) begin @(negedge clk); n++; end
        chk("D_completed_seen", int'(complD), 1);
        chk("D_latency", cyc - t0, 66049);
        chk("D_best_model", int'(bestD), eb);
        chk("D_best_literal", int'(bestD), 65280);
        chk("D_mx_literal", int'(mxD), -8);
        chk("D_my_literal", int'(myD), -8);
        doneD = 1'b1;
    end

    initial begin : thr_c
        int eb, ex, ey, t0, n, lat0, lat1, prev, mode, ox, oy;
        prev = 0;
        for (int i = 0; i < 1024; i++) begin memRC[i] = 8'd0; memSC[i] = 8'd0; end
        wait (rel);
        for (int t = 0; t < 16; t++) begin
            mode = t % 4;
            for (int i = 0; i < 49; i++)
                memSC[i] = (mode == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            for (int i = 0; i < 16; i++)
                memRC[i] = (mode == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (mode == 2) begin
                ox = int'($urandom_range(0, 3));
                oy = int'($urandom_range(0, 3));
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        memRC[row * 4 + col] = memSC[(row + oy) * 7 + col + ox];
            end
            ref_search(4, 2, memRC, memSC, eb, ex, ey);
            @(negedge clk); startC = 1'b1;
            @(negedge clk); startC = 1'b0; t0 = cyc;
            lat0 = -1; lat1 = -1; n = 0;
            while ((lat0 < 0 || lat1 < 0) && n < 400) begin
                if (n == 10) chk($sformatf("C0_result_held_t%0d", t), int'(bestC0), prev);
                @(negedge clk); n++;
                if (complC0 && lat0 < 0) begin
                    lat0 = cyc - t0;
                    chk($sformatf("C0_best_t%0d", t), int'(bestC0), eb);
                    chk($sformatf("C0_mx_t%0d", t), int'(mxC0), ex);
                    chk($sformatf("C0_my_t%0d", t), int'(myC0), ey);
                end
                if (complC1 && lat1 < 0) begin
                    lat1 = cyc - t0;
                    chk($sformatf("C1_best_t%0d", t), int'(bestC1), eb);
                    chk($sformatf("C1_mx_t%0d", t), int'(mxC1), ex);
                    chk($sformatf("C1_my_t%0d", t), int'(myC1), ey);
                end
            end
            chk($sformatf("C0_latency_t%0d", t), lat0, 289);
            chk($sformatf("C1_latency_bound_t%0d", t), int'(lat1 > 0 && lat1 <= 289), 1);
            prev = eb;
        end
        doneC = 1'b1;
    end

    initial begin : main
        int n;
        #1 rst_glb_n = 1'b0;
        #1;
        chk("A_rst_busy", int'(busyA), 0);
        chk("A_rst_completed", int'(complA), 0);
        chk("A_rst_best", int'(bestA), 0);
        chk("A_rst_mx", int'(mxA), 0);
        chk("A_rst_my", int'(myA), 0);
        chk("A_rst_addrR", int'(arA), 0);
        chk("A_rst_addrS", int'(asA), 0);
        chk("C0_rst_busy", int'(busyC0), 0);
        chk("C0_rst_best", int'(bestC0), 0);
        chk("C1_rst_completed", int'(complC1), 0);
        repeat (3) @(negedge clk);
        rst_glb_n = 1'b1;
        rel = 1'b1;
        n = 0;
        while (!(doneA && doneB && doneC && doneD) && n < 90000) begin
            @(negedge clk); n++;
        end
        chk("all_threads_done", int'(doneA && doneB && doneC && doneD), 1);
        chk("A_completed_pulses", nComplA, 1);
        chk("B_completed_pulses", nComplB, 1);
        chk("D_completed_pulses", nComplD, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
